// File: rtl/bp_pkg.sv
// Shared types and index/tag helpers for the branch target buffer.
package bp_pkg;

    localparam int BTB_DEPTH = 6;
    localparam int TAG_WIDTH = 8;
    localparam int BTB_SETS  = 1 << BTB_DEPTH;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [29:0]          target;
    } btb_entry_t;

    function automatic logic [BTB_DEPTH-1:0] btb_index(input logic [31:0] pc);
        return pc[BTB_DEPTH+1:2];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] btb_tag(input logic [31:0] pc);
        return pc[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2];
    endfunction

endpackage

// File: rtl/bp_btb_way.sv
// One BTB way: resettable valid bits plus a tag/target array, one write port
// and two combinational read ports (fetch and memory stage).
module bp_btb_way
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [BTB_DEPTH-1:0] wrIdx,
    input  btb_entry_t           wrEntry,
    input  logic [BTB_DEPTH-1:0] rdIdxF,
    output btb_entry_t           rdEntryF,
    input  logic [BTB_DEPTH-1:0] rdIdxM,
    output btb_entry_t           rdEntryM
);

    logic [BTB_SETS-1:0]       validReg;
    logic [TAG_WIDTH+29:0]     dataMem [BTB_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validReg <= '0;
        end else if (we) begin
            validReg[wrIdx] <= wrEntry.valid;
        end
    end

    // Tag/target storage needs no reset: a cleared valid bit masks it.
    always_ff @(posedge clk) begin
        if (we) begin
            dataMem[wrIdx] <= {wrEntry.tag, wrEntry.target};
        end
    end

    assign rdEntryF = {validReg[rdIdxF], dataMem[rdIdxF]};
    assign rdEntryM = {validReg[rdIdxM], dataMem[rdIdxM]};

endmodule

// File: rtl/bp_btb.sv
// 2-way set-associative branch target buffer with per-set LRU.
// Optional BTB_STATS_EN adds saturating update/target-miss counters.
module bp_btb
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        pcsrcPF,
    output logic        btb_hitF,
    output logic        pred_takenF,
    output logic [31:0] pc_predF,
    input  logic        branchM,
    input  logic        pcsrcM,
    input  logic [31:0] pcM,
    input  logic [31:0] branch_targetM,
`ifdef BTB_STATS_EN
    output logic [31:0] btb_lookup_cnt,
    output logic [31:0] btb_tgt_miss_cnt,
`endif
    output logic        tgt_mispredM
);

    logic [BTB_DEPTH-1:0] idxF, idxM;
    logic [TAG_WIDTH-1:0] tagF, tagM;
    btb_entry_t           entF [2];
    btb_entry_t           entM [2];
    btb_entry_t           wrEntry;
    logic [1:0]           hitF, hitM, we;
    logic [BTB_SETS-1:0]  lruReg;
    logic [29:0]          tgtF, tgtM;
    logic                 hitAnyM, update, wrWay;

    assign idxF = btb_index(pcF);
    assign tagF = btb_tag(pcF);
    assign idxM = btb_index(pcM);
    assign tagM = btb_tag(pcM);

    assign update  = branchM & pcsrcM;
    assign wrEntry = '{valid: 1'b1, tag: tagM, target: branch_targetM[31:2]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gWay
            bp_btb_way uWay (
                .clk      (clk),
                .rst      (rst),
                .we       (we[gi]),
                .wrIdx    (idxM),
                .wrEntry  (wrEntry),
                .rdIdxF   (idxF),
                .rdEntryF (entF[gi]),
                .rdIdxM   (idxM),
                .rdEntryM (entM[gi])
            );
            assign hitF[gi] = entF[gi].valid && (entF[gi].tag == tagF);
            assign hitM[gi] = entM[gi].valid && (entM[gi].tag == tagM);
            assign we[gi]   = update && (wrWay == gi[0]);
        end
    endgenerate

    // Way0 takes priority should both ways ever match.
    assign tgtF        = hitF[0] ? entF[0].target : entF[1].target;
    assign btb_hitF    = |hitF;
    assign pred_takenF = btb_hitF & pcsrcPF;
    assign pc_predF    = pred_takenF ? {tgtF, 2'b00} : pcF + 32'd4;

    assign tgtM         = hitM[0] ? entM[0].target : entM[1].target;
    assign hitAnyM      = |hitM;
    assign tgt_mispredM = update & (~hitAnyM | ({tgtM, 2'b00} != branch_targetM));

    // Victim: hit way, else first invalid way, else the LRU way.
    always_comb begin
        wrWay = lruReg[idxM];
        if (hitM[0])
            wrWay = 1'b0;
        else if (hitM[1])
            wrWay = 1'b1;
        else if (!entM[0].valid)
            wrWay = 1'b0;
        else if (!entM[1].valid)
            wrWay = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lruReg <= '0;
        end else if (update) begin
            lruReg[idxM] <= ~wrWay;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookupCntReg, tgtMissCntReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookupCntReg  <= '0;
            tgtMissCntReg <= '0;
        end else if (update) begin
            if (lookupCntReg != 32'hFFFF_FFFF)
                lookupCntReg <= lookupCntReg + 32'd1;
            if (tgt_mispredM && tgtMissCntReg != 32'hFFFF_FFFF)
                tgtMissCntReg <= tgtMissCntReg + 32'd1;
        end
    end

    assign btb_lookup_cnt   = lookupCntReg;
    assign btb_tgt_miss_cnt = tgtMissCntReg;
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb; expectations are queued at drive time and
// popped after the combinational outputs settle.
module tb_bp_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic        pcsrcPF = 1'b0;
    logic        btb_hitF, pred_takenF, tgt_mispredM;
    logic [31:0] pc_predF;
    logic        branchM = 1'b0;
    logic        pcsrcM = 1'b0;
    logic [31:0] pcM = '0;
    logic [31:0] branch_targetM = '0;
`ifdef BTB_STATS_EN
    logic [31:0] btb_lookup_cnt, btb_tgt_miss_cnt;
`endif

    int passCnt = 0;
    int totalCnt = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    bp_btb dut (
        .clk            (clk),
        .rst            (rst),
        .pcF            (pcF),
        .pcsrcPF        (pcsrcPF),
        .btb_hitF       (btb_hitF),
        .pred_takenF    (pred_takenF),
        .pc_predF       (pc_predF),
        .branchM        (branchM),
        .pcsrcM         (pcsrcM),
        .pcM            (pcM),
        .branch_targetM (branch_targetM),
`ifdef BTB_STATS_EN
        .btb_lookup_cnt   (btb_lookup_cnt),
        .btb_tgt_miss_cnt (btb_tgt_miss_cnt),
`endif
        .tgt_mispredM   (tgt_mispredM)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        totalCnt++;
        assert (obs === expv) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    endtask

    task automatic step(input string name, input logic rstV,
                        input logic [31:0] pf, input logic ppf,
                        input logic br, input logic src,
                        input logic [31:0] pm, input logic [31:0] tgt,
                        input logic eHit, input logic eTaken,
                        input logic [31:0] ePc, input logic eMis);
        exp_t e;
        @(negedge clk);
        rst = rstV;
        pcF = pf;
        pcsrcPF = ppf;
        branchM = br;
        pcsrcM = src;
        pcM = pm;
        branch_targetM = tgt;
        sb.push_back('{name, eHit, eTaken, ePc, eMis});
        #1;
        e = sb.pop_front();
        chk({e.name, ".hit"}, {31'd0, btb_hitF}, {31'd0, e.hit});
        chk({e.name, ".taken"}, {31'd0, pred_takenF}, {31'd0, e.taken});
        chk({e.name, ".pc"}, pc_predF, e.pc);
        chk({e.name, ".mis"}, {31'd0, tgt_mispredM}, {31'd0, e.mis});
        $display("step %-12s pcF=%h hit=%b taken=%b pc_pred=%h mis=%b",
                 e.name, pf, btb_hitF, pred_takenF, pc_predF, tgt_mispredM);
    endtask

    initial begin
        logic [31:0] t, ePc;
        repeat (2) @(posedge clk);
        // name          rst pcF           pP br sM pcM           target        hit tk pc_pred       mis
        step("rst_lookup", 1, 32'h0040_0000, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0004, 0);
        step("alloc",      0, 32'h0040_0000, 0, 1, 1, 32'h0040_0010, 32'h0040_0100, 0, 0, 32'h0040_0004, 1);
        step("hit_t",      0, 32'h0040_0010, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_0100, 0);
        step("hit_nt",     0, 32'h0040_0010, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0040_0014, 0);
        step("allocA",     0, 32'h0040_0020, 1, 1, 1, 32'h0040_0020, 32'h0040_1000, 0, 0, 32'h0040_0024, 1);
        step("allocB",     0, 32'h0040_0020, 1, 1, 1, 32'h0040_0120, 32'h0040_1100, 1, 1, 32'h0040_1000, 1);
        step("allocC",     0, 32'h0040_0120, 1, 1, 1, 32'h0040_0220, 32'h0040_1200, 1, 1, 32'h0040_1100, 1);
        step("A_evicted",  0, 32'h0040_0020, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0024, 0);
        step("B_hit",      0, 32'h0040_0120, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_1100, 0);
        step("C_hit",      0, 32'h0040_0220, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_1200, 0);
        step("retrainB",   0, 32'h0040_0120, 1, 1, 1, 32'h0040_0120, 32'h0040_0200, 1, 1, 32'h0040_1100, 1);
        step("B_new",      0, 32'h0040_0120, 1, 1, 1, 32'h0040_0120, 32'h0040_0200, 1, 1, 32'h0040_0200, 0);
        step("allocD",     0, 32'h0040_0220, 1, 1, 1, 32'h0040_0320, 32'h0040_1300, 1, 1, 32'h0040_1200, 1);
        step("C_evicted",  0, 32'h0040_0220, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0224, 0);
        step("D_hit",      0, 32'h0040_0320, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_1300, 0);
        step("B_kept",     0, 32'h0040_0120, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_0200, 0);
        step("nt_noalloc", 0, 32'h0040_0030, 1, 1, 0, 32'h0040_0030, 32'h0040_3000, 0, 0, 32'h0040_0034, 0);
        step("same_set",   0, 32'h0040_0030, 1, 1, 1, 32'h0040_0030, 32'h0040_3000, 0, 0, 32'h0040_0034, 1);
        step("same_next",  0, 32'h0040_0030, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0040_3000, 0);
        step("wrap",       0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 0);
        step("br_off",     0, 32'h0000_0000, 1, 0, 1, 32'h0040_0040, 32'h0040_5000, 0, 0, 32'h0000_0004, 0);
        step("br_off_chk", 0, 32'h0040_0040, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0044, 0);
        step("rst_mid",    1, 32'h0040_0010, 1, 1, 1, 32'h0040_0050, 32'h0040_6000, 0, 0, 32'h0040_0014, 1);
        step("rst_B",      0, 32'h0040_0120, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0124, 0);
        step("rst_D",      0, 32'h0040_0320, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0324, 0);
        step("rst_wr",     0, 32'h0040_0050, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0040_0054, 0);

        // Ten taken updates to one entry; the first three carry new targets.
        for (int i = 0; i < 10; i++) begin
            t = (i < 3) ? 32'h0040_4000 + 32'(i) * 32'h100 : 32'h0040_4200;
            ePc = (i == 0) ? 32'h0040_0044 :
                  (i < 4)  ? 32'h0040_4000 + 32'(i - 1) * 32'h100 : 32'h0040_4200;
            step($sformatf("stat%0d", i), 0, 32'h0040_0040, 1, 1, 1, 32'h0040_0040, t,
                 (i != 0), (i != 0), ePc, (i < 3));
        end
        @(negedge clk);
        branchM = 1'b0;
        pcsrcM = 1'b0;
`ifdef BTB_STATS_EN
        #1;
        chk("lookup_cnt", btb_lookup_cnt, 32'd10);
        chk("tgt_miss_cnt", btb_tgt_miss_cnt, 32'd3);
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
